// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the integer multiply/divide unit.
//   muldiv_op_e : operation encoding presented on op_i
//   divfsm_e    : serial divider state encoding
//   is_mul / is_div / is_word / is_signed_div / is_rem / mul_signs / sext32
package muldiv_pkg;

    typedef enum logic [3:0] {
        MUL, MULH, MULHU, MULHSU, MULW,
        DIV, DIVU, DIVW, DIVUW,
        REM, REMU, REMW, REMUW
    } muldiv_op_e;

    typedef enum logic [2:0] {
        DIV_IDLE, DIV_PREP, DIV_ITER, DIV_FIX, DIV_DONE
    } divfsm_e;

    function automatic logic is_mul(input muldiv_op_e op);
        return op inside {MUL, MULH, MULHU, MULHSU, MULW};
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return !is_mul(op);
    endfunction

    function automatic logic is_word(input muldiv_op_e op);
        return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic is_signed_div(input muldiv_op_e op);
        return op inside {DIV, DIVW, REM, REMW};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {REM, REMU, REMW, REMUW};
    endfunction

    // {operand_a signed, operand_b signed}
    function automatic logic [1:0] mul_signs(input muldiv_op_e op);
        case (op)
            MULHU:   return 2'b00;
            MULHSU:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_serdiv.sv
// muldiv_serdiv: serial radix-2 restoring divider with its own valid/ready result port.
//   clk_i, rst_i (async active-high), flush_i (abandon current operation)
//   in_valid_i / in_ready_o : start request, accepted only in IDLE
//   op_i, operand_a_i, operand_b_i, trans_id_i : request payload
//   out_valid_o / out_ready_i, result_o, trans_id_o : result held in DONE until taken
// Optional: MULDIV_DIV_EARLY_EXIT_EN pre-shifts the dividend past its leading
// zeros so the iteration count becomes data dependent (results unchanged).
module muldiv_serdiv
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TID_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  muldiv_op_e       op_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic [TID_W-1:0] trans_id_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TID_W-1:0] trans_id_o
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic        HAS_W = (XLEN == 64);

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
        logic [63:0] t;
        t = s ? sext32(v) : {32'b0, v};
        return t[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic word);
        return word ? ext32(v[31:0], 1'b1) : v;
    endfunction

    divfsm_e state_q, state_d;

    logic [XLEN-1:0]  a_q, b_q, divisor_q, quo_q, rem_acc_q, res_q;
    logic             sgn_q, rem_q, word_q, neg_a_q, neg_b_q;
    logic [TID_W-1:0] tid_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept, word_in, sgn_in;
    logic [XLEN-1:0]  a_in, b_in;
    logic             neg_a, neg_b, b_zero, ovf;
    logic [XLEN-1:0]  abs_a, abs_b, min_val, aligned, pre;
    logic [CNT_W-1:0] n_bits, base_sh, iters;
    logic [XLEN:0]    trial, diff;
    logic             ge;
    logic [XLEN-1:0]  q_fix, r_fix;

    assign in_ready_o  = (state_q == DIV_IDLE);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign out_valid_o = (state_q == DIV_DONE);
    assign result_o    = res_q;
    assign trans_id_o  = tid_q;

    // Request decode: W-ops only exist when XLEN is 64.
    always_comb begin
        word_in = HAS_W && is_word(op_i);
        sgn_in  = is_signed_div(op_i);
        a_in    = word_in ? ext32(operand_a_i[31:0], sgn_in) : operand_a_i;
        b_in    = word_in ? ext32(operand_b_i[31:0], sgn_in) : operand_b_i;
    end

    // PREP: magnitudes, special cases and the iteration plan.
    always_comb begin
        neg_a   = sgn_q && a_q[XLEN-1];
        neg_b   = sgn_q && b_q[XLEN-1];
        abs_a   = neg_a ? -a_q : a_q;
        abs_b   = neg_b ? -b_q : b_q;
        b_zero  = (b_q == '0);
        min_val = word_q ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        ovf     = sgn_q && (a_q == min_val) && (b_q == '1);
        n_bits  = word_q ? CNT_W'(32) : CNT_W'(XLEN);
        base_sh = word_q ? CNT_W'(XLEN - 32) : '0;
        // Left-align the N-bit dividend so every ITER step consumes the MSB.
        aligned = abs_a << base_sh;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
        begin
            logic [CNT_W-1:0] lz;
            lz = n_bits;
            for (int unsigned i = 0; i < XLEN; i++) begin
                if (aligned[i]) lz = CNT_W'(XLEN - 1 - i);
            end
            iters = (lz >= n_bits) ? CNT_W'(1) : n_bits - lz;
            pre   = aligned << lz;
        end
`else
        iters = n_bits;
        pre   = aligned;
`endif
    end

    // ITER: one restoring shift-subtract step.
    always_comb begin
        trial = {rem_acc_q, quo_q[XLEN-1]};
        diff  = trial - {1'b0, divisor_q};
        ge    = !diff[XLEN];
    end

    always_comb begin
        q_fix = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
        r_fix = neg_a_q ? -rem_acc_q : rem_acc_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (accept) state_d = DIV_PREP;
            DIV_PREP: state_d = (b_zero || ovf) ? DIV_DONE : DIV_ITER;
            DIV_ITER: if (cnt_q == CNT_W'(1)) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_DONE;
            DIV_DONE: if (out_ready_i) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush_i) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_acc_q <= '0;
            res_q     <= '0;
            sgn_q     <= 1'b0;
            rem_q     <= 1'b0;
            word_q    <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            tid_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: if (accept) begin
                    a_q    <= a_in;
                    b_q    <= b_in;
                    sgn_q  <= sgn_in;
                    rem_q  <= is_rem(op_i);
                    word_q <= word_in;
                    tid_q  <= trans_id_i;
                end
                DIV_PREP: begin
                    neg_a_q   <= neg_a;
                    neg_b_q   <= neg_b;
                    divisor_q <= abs_b;
                    rem_acc_q <= '0;
                    quo_q     <= pre;
                    cnt_q     <= iters;
                    if (b_zero)   res_q <= fin(rem_q ? a_q : '1, word_q);
                    else if (ovf) res_q <= fin(rem_q ? '0 : a_q, word_q);
                end
                DIV_ITER: begin
                    quo_q     <= {quo_q[XLEN-2:0], ge};
                    rem_acc_q <= ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
                    cnt_q     <= cnt_q - CNT_W'(1);
                end
                DIV_FIX: res_q <= fin(rem_q ? r_fix : q_fix, word_q);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: integer multiply/divide unit for the execute stage.
//   clk_i, rst_i (async active-high), flush_i (kill everything in flight)
//   in_valid_i / in_ready_o, op_i, operand_a_i, operand_b_i, trans_id_i : request
//   out_valid_o / out_ready_i, result_o, trans_id_o : shared result port
// Multiplier: MUL_STAGES-deep stallable pipe. Divider: muldiv_serdiv.
// Results may complete out of order; arbitration alternates under contention.
// Optional: MULDIV_DIV_EARLY_EXIT_EN (see muldiv_serdiv).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TID_W      = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  muldiv_op_e       op_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic [TID_W-1:0] trans_id_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TID_W-1:0] trans_id_o
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned LAST  = MUL_STAGES - 1;
    localparam logic        HAS_W = (XLEN == 64);

    typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_W} mul_sel_e;

    function automatic logic [XLEN-1:0] wext(input logic [31:0] v);
        logic [63:0] t;
        t = sext32(v);
        return t[XLEN-1:0];
    endfunction

    logic             op_is_mul, mul_accept, div_start, mul_adv;
    logic             mul_req, div_req, sel_mul, mul_grant, div_grant, prio_div_q;
    logic             div_in_ready;
    logic [XLEN-1:0]  div_result, mul_result;
    logic [TID_W-1:0] div_tid;
    logic [1:0]       signs;
    logic [PW-1:0]    ma, mb, mp;
    mul_sel_e         sel_in;

    logic [MUL_STAGES-1:0] st_valid;
    logic [PW-1:0]         st_prod [MUL_STAGES];
    logic [TID_W-1:0]      st_tid  [MUL_STAGES];
    mul_sel_e              st_sel  [MUL_STAGES];

    assign op_is_mul  = is_mul(op_i);
    assign in_ready_o = !flush_i && (op_is_mul ? mul_adv : div_in_ready);
    assign mul_accept = in_valid_i && in_ready_o && op_is_mul;
    assign div_start  = in_valid_i && in_ready_o && !op_is_mul;

    // Sign/zero extension straight to 2*XLEN: the low 2*XLEN bits of this
    // product equal those of the (XLEN+1)-bit signed product.
    always_comb begin
        signs = mul_signs(op_i);
        ma    = {{XLEN{signs[1] & operand_a_i[XLEN-1]}}, operand_a_i};
        mb    = {{XLEN{signs[0] & operand_b_i[XLEN-1]}}, operand_b_i};
        mp    = ma * mb;
        case (op_i)
            MUL:     sel_in = SEL_LO;
            MULW:    sel_in = HAS_W ? SEL_W : SEL_LO;
            default: sel_in = SEL_HI;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_valid <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                st_prod[i] <= '0;
                st_tid[i]  <= '0;
                st_sel[i]  <= SEL_LO;
            end
        end else begin
            if (mul_adv) begin
                st_valid[0] <= mul_accept;
                st_prod[0]  <= mp;
                st_tid[0]   <= trans_id_i;
                st_sel[0]   <= sel_in;
                for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                    st_valid[i] <= st_valid[i-1];
                    st_prod[i]  <= st_prod[i-1];
                    st_tid[i]   <= st_tid[i-1];
                    st_sel[i]   <= st_sel[i-1];
                end
            end
            if (flush_i) st_valid <= '0;
        end
    end

    always_comb begin
        case (st_sel[LAST])
            SEL_HI:  mul_result = st_prod[LAST][PW-1:XLEN];
            SEL_W:   mul_result = wext(st_prod[LAST][31:0]);
            default: mul_result = st_prod[LAST][XLEN-1:0];
        endcase
    end

    muldiv_serdiv #(
        .XLEN  (XLEN),
        .TID_W (TID_W)
    ) u_serdiv (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (div_start),
        .in_ready_o  (div_in_ready),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .trans_id_i  (trans_id_i),
        .out_valid_o (div_req),
        .out_ready_i (div_grant),
        .result_o    (div_result),
        .trans_id_o  (div_tid)
    );

    // prio_div_q=0 favours the multiplier; flips on every contended handshake.
    assign mul_req   = st_valid[LAST];
    assign sel_mul   = mul_req && (!div_req || !prio_div_q);
    assign mul_grant = sel_mul && out_ready_i;
    assign div_grant = div_req && !sel_mul && out_ready_i;
    assign mul_adv   = !mul_req || mul_grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                     prio_div_q <= 1'b0;
        else if (mul_req && div_req && out_ready_i)    prio_div_q <= !prio_div_q;
    end

    assign out_valid_o = mul_req || div_req;
    assign result_o    = !out_valid_o ? '0 : (sel_mul ? mul_result : div_result);
    assign trans_id_o  = !out_valid_o ? '0 : (sel_mul ? st_tid[LAST] : div_tid);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 64;
    localparam int MUL_STAGES = 2;
    localparam int TID_W = 3;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    muldiv_op_e       op_i = MUL;
    logic [XLEN-1:0]  operand_a_i = '0;
    logic [XLEN-1:0]  operand_b_i = '0;
    logic [TID_W-1:0] trans_id_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [XLEN-1:0]  result_o;
    logic [TID_W-1:0] trans_id_o;

    muldiv_unit #(
        .XLEN       (XLEN),
        .MUL_STAGES (MUL_STAGES),
        .TID_W      (TID_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .trans_id_i  (trans_id_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .trans_id_o  (trans_id_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [TID_W-1:0] tid;
        logic [63:0]      res;
        int               lat;
        bit               chk_lat;
        int               t0;
    } exp_t;

    exp_t             sb[$];
    logic [TID_W-1:0] seen[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    // Expected divider latency: N+3, or max(1, N-lzc)+3 with early exit.
    function automatic int div_lat(input bit word, input logic [63:0] abs_a);
        int n;
        n = word ? 32 : 64;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
        begin
            int msb;
            msb = -1;
            for (int i = 0; i < n; i++) if (abs_a[i]) msb = i;
            return ((msb < 0) ? 1 : msb + 1) + 3;
        end
`else
        return n + abs_a[0] * 0 + 3;
`endif
    endfunction

    // Monitor: pops the matching tid whenever a result handshake happens.
    initial forever begin
        @(negedge clk_i);
        #1;
        if (!rst_i && out_valid_o && out_ready_i) begin
            int idx;
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].tid == trans_id_o) idx = i;
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL unexpected_result: got tid %0d result 0x%h, required no output", trans_id_o, result_o);
            end else begin
                check($sformatf("result_tid%0d", trans_id_o), result_o, sb[idx].res);
                if (sb[idx].chk_lat)
                    check($sformatf("latency_tid%0d", trans_id_o), 64'(cyc - sb[idx].t0), 64'(sb[idx].lat));
                seen.push_back(trans_id_o);
                sb.delete(idx);
            end
        end
    end

    task automatic issue(input muldiv_op_e op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TID_W-1:0] tid, input logic [63:0] res,
                         input int lat, input bit chk_lat, input bit expect_out);
        int budget;
        exp_t e;
        @(negedge clk_i);
        op_i = op;
        operand_a_i = a;
        operand_b_i = b;
        trans_id_i = tid;
        in_valid_i = 1'b1;
        #1;
        budget = 0;
        while (!in_ready_o && budget < 200) begin
            @(negedge clk_i);
            #1;
            budget++;
        end
        if (!in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout_tid%0d: got in_ready_o=0, required 1", tid);
            in_valid_i = 1'b0;
            return;
        end
        if (expect_out) begin
            e.tid = tid; e.res = res; e.lat = lat; e.chk_lat = chk_lat; e.t0 = cyc;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        #2;
        check("drain_outstanding", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_i);
        #1;
        check("reset_out_valid", 64'(out_valid_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_tid", 64'(trans_id_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("reset_in_ready_mul", 64'(in_ready_o), 64'd1);

        // Multiplier, single and back-to-back.
        issue(MUL, 64'd7, 64'hFFFFFFFFFFFFFFFD, 3'd5, 64'hFFFFFFFFFFFFFFEB, 2, 1, 1);
        wait_empty(20);
        issue(MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFE, 2, 1, 1);
        issue(MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'd2, 3'd2, 64'hFFFFFFFFFFFFFFFF, 2, 1, 1);
        issue(MULH, 64'h8000000000000000, 64'd2, 3'd3, 64'hFFFFFFFFFFFFFFFF, 2, 1, 1);
        issue(MULW, 64'h000000007FFFFFFF, 64'd2, 3'd4, 64'hFFFFFFFFFFFFFFFE, 2, 1, 1);
        wait_empty(20);

        // Divider: normal, word and special cases.
        issue(DIV, 64'hFFFFFFFFFFFFFFEC, 64'd3, 3'd5, 64'hFFFFFFFFFFFFFFFA, div_lat(0, 64'd20), 1, 1);
        wait_empty(200);
        issue(REM, 64'hFFFFFFFFFFFFFFEC, 64'd3, 3'd6, 64'hFFFFFFFFFFFFFFFE, div_lat(0, 64'd20), 1, 1);
        wait_empty(200);
        issue(DIVW, 64'h0000000180000000, 64'hFFFFFFFFFFFFFFFF, 3'd7, 64'hFFFFFFFF80000000, 2, 1, 1);
        wait_empty(20);
        issue(DIVU, 64'd123, 64'd0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 2, 1, 1);
        wait_empty(20);
        issue(REMU, 64'd9, 64'd0, 3'd1, 64'd9, 2, 1, 1);
        wait_empty(20);
        issue(DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 3'd2, 64'h8000000000000000, 2, 1, 1);
        wait_empty(20);
        issue(DIVU, 64'd100, 64'd7, 3'd3, 64'd14, div_lat(0, 64'd100), 1, 1);
        wait_empty(200);
        issue(REMW, 64'h12345678FFFFFFF9, 64'd2, 3'd4, 64'hFFFFFFFFFFFFFFFF, div_lat(1, 64'd7), 1, 1);
        wait_empty(200);
        issue(DIVUW, 64'hFFFFFFFFFFFFFFFE, 64'h0000000100000002, 3'd5, 64'h000000007FFFFFFF,
              div_lat(1, 64'hFFFFFFFE), 1, 1);
        wait_empty(200);

        // Backpressure: one DIV and two MULs complete while out_ready_i is low.
        @(negedge clk_i);
        out_ready_i = 1'b0;
        issue(DIVU, 64'd5, 64'd0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 0, 0, 1);
        issue(MUL, 64'd3, 64'd5, 3'd2, 64'd15, 0, 0, 1);
        issue(MUL, 64'd6, 64'd7, 3'd3, 64'd42, 0, 0, 1);
        op_i = MUL;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #1;
            check($sformatf("bp_in_ready_c%0d", i), 64'(in_ready_o), 64'd0);
            check($sformatf("bp_out_valid_c%0d", i), 64'(out_valid_o), 64'd1);
            check($sformatf("bp_tid_c%0d", i), 64'(trans_id_o), 64'd2);
            check($sformatf("bp_result_c%0d", i), result_o, 64'd15);
        end
        seen.delete();
        @(negedge clk_i);
        out_ready_i = 1'b1;
        wait_empty(20);
        check("bp_result_count", 64'(seen.size()), 64'd3);
        begin
            logic [TID_W-1:0] order [3];
            order[0] = 3'd2; order[1] = 3'd1; order[2] = 3'd3;
            for (int i = 0; i < 3; i++)
                if (i < seen.size()) check($sformatf("bp_order_%0d", i), 64'(seen[i]), 64'(order[i]));
        end

        // Flush mid-division; a request in the flush cycle must be dropped.
        issue(DIV, 64'd100, 64'd7, 3'd6, 64'd0, 0, 0, 0);
        repeat (8) @(negedge clk_i);
        flush_i = 1'b1;
        op_i = MUL;
        operand_a_i = 64'd2;
        operand_b_i = 64'd3;
        trans_id_i = 3'd7;
        in_valid_i = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid_o), 64'd0);
        check("flush_in_ready_mul", 64'(in_ready_o), 64'd1);
        op_i = DIV;
        #1;
        check("flush_in_ready_div", 64'(in_ready_o), 64'd1);
        repeat (80) @(negedge clk_i);
        issue(MUL, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFFB, 3'd7, 64'd25, 2, 1, 1);
        wait_empty(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised integer multiply/divide functional unit for the RV64/RV32 execute stage. It supersedes the fixed 64-bit mult wrapper.
- Contains a configurable-depth multiplier pipeline that can be stalled, and a serial radix-2 divider.
- The divider handles word ops in a shortened loop and resolves special cases in a fast path.
- Both engines share a single valid/ready result port with fair arbitration; results are tagged with trans_id and may complete out of order.

Parameters:
- XLEN, 64, operand/result width; 32 or 64. W-ops are treated as their non-W form when XLEN=32.
- MUL_STAGES, 2, number of multiplier register stages (1..4). Sets MUL latency.
- TID_W, 3, trans_id width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  kills all in-flight operations.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- op_i  in  muldiv_op_e  operation: MUL, MULH, MULHU, MULHSU, MULW, DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW.
- operand_a_i  in  XLEN  rs1.
- operand_b_i  in  XLEN  rs2.
- trans_id_i  in  TID_W  tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result.
- trans_id_o  out  TID_W  tag of result_o.

Behaviour:
- Reset (asynchronous, active-high clk_i/rst_i as decided: one clock, asynchronous active-high reset):
  - all stage valids 0; divider FSM in IDLE; arbiter priority bit = MUL.
  - out_valid_o=0, result_o=0, trans_id_o=0.
  - Reset mid-division abandons the operation with no output.
- in_ready_o:
  - For a MUL-class op_i: equals mul_adv.
  - For a DIV-class op_i: equals (FSM==IDLE).
  - Forced 0 while flush_i=1.
  - Depends combinationally on op_i. Upstream holds op_i stable while in_valid_i is asserted.
- Multiplier:
  - Operands are extended by one bit, signed or unsigned per op. The full 2*XLEN product is computed and carried through MUL_STAGES registers.
  - mul_adv = !last_stage_valid || mul_grant. The whole pipe holds when mul_adv=0, and stage contents stay stable.
  - Result selection:
    - MUL: low XLEN bits.
    - MULH/MULHU/MULHSU: high XLEN bits.
    - MULW: sext of low 32 bits of the 32x32 product.
  - Latency: out_valid_o is asserted MUL_STAGES cycles after acceptance when there is no backpressure.
- Divider FSM IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE:
  - IDLE: on accept, latch operands (W-ops: low 32 bits, sign- or zero-extended per signedness), op, tid, word flag.
  - PREP: take absolute values for signed ops and detect special cases:
    - b==0: quotient = all ones; remainder = a.
    - signed MIN/-1: quotient = MIN; remainder = 0.
    - Special cases go directly to DONE.
    - Otherwise set N = 32 for W-ops, else XLEN, and go to ITER.
  - ITER: one restoring shift-subtract step per cycle, N cycles.
  - FIX: negate quotient if sign(a)^sign(b); negate remainder if sign(a). W-ops sext from bit 31. Go to DONE.
  - DONE: hold the result with its own valid; leave to IDLE on div_grant.
  - Latency: N+3 cycles normal (67 for DIV, 35 for DIVW at XLEN=64); 2 cycles for special cases.
- Arbitration:
  - With a single requester, that requester is granted.
  - When both are valid, the grant alternates; the priority bit flips after each contended grant.
  - Output is registered-free mux of the granted source. A source whose result is not granted holds it stable.
  - No result is ever dropped or duplicated.
- Flush:
  - Next cycle: all mul stage valids=0, FSM=IDLE, out_valid_o=0.
  - A request presented in the same cycle as flush_i is not accepted.

Optional Feature:
- MULDIV_DIV_EARLY_EXIT_EN defined:
  - In PREP, a leading-zero count of |a| (within the N-bit span) pre-shifts the dividend.
  - ITER then runs max(1, N-lzc) cycles. Results are bit-identical; latency becomes data-dependent (a=5 DIV: 3+3=6 cycles).
- Undefined: ITER always runs N cycles.

Decomposition:
- muldiv_pkg holds:
  - muldiv_op_e;
  - functions is_mul, is_div, is_word, is_signed_div, is_rem, mul_signs, sext32;
  - FSM state enum divfsm_e.
- Sub-module muldiv_serdiv (XLEN, TID_W): the divider FSM with its own out valid/ready. The multiplier pipeline and the arbiter stay in muldiv_unit.

Test Plan (XLEN=64, MUL_STAGES=2):
- MUL a=7, b=-3, tid=5 -> out_valid_o 2 cycles later, result 0xFFFFFFFFFFFFFFEB, tid 5.
- MULHU a=b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFFFFFFFFFF.
- DIV a=-20, b=3 -> 0xFFFFFFFFFFFFFFFA after 67 cycles. REM same operands -> 0xFFFFFFFFFFFFFFFE. DIVW a=0x0000000180000000, b=-1 -> 0xFFFFFFFF80000000 after 2 cycles.
- DIVU b=0 -> all ones, 2 cycles. REMU a=9, b=0 -> 9. DIV 0x8000000000000000 / -1 -> 0x8000000000000000.
- Backpressure: hold out_ready_i=0 for 5 cycles with 2 MULs plus a DIV completing:
  - in_ready_o stays 0 for MUL ops;
  - result_o and trans_id_o stay stable;
  - on release, the grant alternates and all 3 tids are seen exactly once.
- flush_i at cycle 10 of a DIV -> no out_valid_o for it, in_ready_o=1 next cycle, and a following MUL returns normally.
